sram_controller: RTL and testbench

Memory-stage responder between the pipeline's `mem_read`/`mem_write` control and an external 16-bit asynchronous SRAM. It accepts one 32-bit word access at a time and performs it as two 16-bit SRAM half-accesses, low half first. While an access is in flight it drives `freeze` to stall IF/ID/EX, and it releases the pipeline with a one-cycle `ready`.

---
 rtl/sram_controller.sv | 210 +++++++++++++++++++++
 tb/tb_sram_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// sram_controller: performs one 32-bit CPU word access as two 16-bit accesses
// on an external asynchronous SRAM, low half first, stalling the pipeline via
// freeze and releasing it with a one-cycle ready pulse.
// Optional feature: define SRAM_READ_CACHE_EN to add a one-entry read cache.

module sram_controller #(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        freeze,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam int            CW   = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_wr_q, op_wr_d;
  logic [16:0]   off_q, off_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [15:0]   rd_lo_q, rd_lo_d;
  logic [31:0]   read_data_q, read_data_d;
  logic          ready_q, ready_d;
  logic [17:0]   sram_addr_q, sram_addr_d;
  logic [15:0]   sram_dq_out_q, sram_dq_out_d;
  logic          sram_dq_oe_q, sram_dq_oe_d;
  logic          sram_we_n_q, sram_we_n_d;
  logic          sram_oe_n_q, sram_oe_n_d;

  logic        req;
  logic        last;
  logic        hit;
  logic [31:0] cache_rdata;
  logic [31:0] diff;
  logic [16:0] off_in;
  logic        unused_diff_bits;

  assign req    = mem_read | mem_write;
  assign last   = (cnt_q == LAST);
  // Word offset from the SRAM base; bits above off[16] alias onto the same words.
  assign diff   = address - BASE_ADDR;
  assign off_in = diff[18:2];
  assign unused_diff_bits = ^{diff[31:19], diff[1:0]};

`ifdef SRAM_READ_CACHE_EN
  logic        cache_valid_q;
  logic [29:0] cache_tag_q;
  logic [31:0] cache_data_q;
  logic [29:0] tag_q, tag_d;

  assign hit         = mem_read & ~mem_write & cache_valid_q & (cache_tag_q == address[31:2]);
  assign cache_rdata = cache_data_q;

  // Remember the full word tag of the access in flight.
  always_comb begin
    tag_d = tag_q;
    if (state_q == S_IDLE && req) tag_d = address[31:2];
  end

  // Fill on every completed read; keep cached data coherent with completed writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
      tag_q         <= '0;
    end else begin
      tag_q <= tag_d;
      if (state_q == S_DONE) begin
        if (!op_wr_q) begin
          cache_valid_q <= 1'b1;
          cache_tag_q   <= tag_q;
          cache_data_q  <= read_data_q;
        end else if (cache_valid_q && cache_tag_q == tag_q) begin
          cache_data_q  <= wdata_q;
        end
      end
    end
  end
`else
  assign hit         = 1'b0;
  assign cache_rdata = 32'h0;
`endif

  // Next-state logic: sequence IDLE -> LOW -> HIGH -> DONE, each half WAIT_CYCLES long.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_wr_d = mem_write;
          off_d   = off_in;
          wdata_d = write_data;
          cnt_d   = '0;
          state_d = hit ? S_DONE : S_LOW;
        end
      end
      S_LOW: begin
        if (last) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered SRAM strobes derived from where the FSM will be next cycle;
  // WE rises on the last cycle of a write half so the address moves with WE high.
  always_comb begin
    sram_addr_d   = sram_addr_q;
    sram_dq_out_d = sram_dq_out_q;
    sram_dq_oe_d  = 1'b0;
    sram_we_n_d   = 1'b1;
    sram_oe_n_d   = 1'b1;
    ready_d       = (state_d == S_DONE);
    if (state_d == S_LOW || state_d == S_HIGH) begin
      sram_addr_d = {off_d, state_d == S_HIGH};
      if (op_wr_d) begin
        sram_dq_oe_d  = 1'b1;
        sram_dq_out_d = (state_d == S_HIGH) ? wdata_d[31:16] : wdata_d[15:0];
        sram_we_n_d   = (cnt_d == LAST);
      end else begin
        sram_oe_n_d = 1'b0;
      end
    end
  end

  // Read capture on the last cycle of each read half; cache hits load directly.
  always_comb begin
    rd_lo_d     = rd_lo_q;
    read_data_d = read_data_q;
    if (state_q == S_LOW && last && !op_wr_q) rd_lo_d = sram_dq_in;
    if (state_q == S_HIGH && last && !op_wr_q) read_data_d = {sram_dq_in, rd_lo_q};
    if (state_q == S_IDLE && req && hit) read_data_d = cache_rdata;
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_wr_q       <= 1'b0;
      off_q         <= '0;
      wdata_q       <= '0;
      rd_lo_q       <= '0;
      read_data_q   <= '0;
      ready_q       <= 1'b0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
      sram_oe_n_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_wr_q       <= op_wr_d;
      off_q         <= off_d;
      wdata_q       <= wdata_d;
      rd_lo_q       <= rd_lo_d;
      read_data_q   <= read_data_d;
      ready_q       <= ready_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_we_n_q   <= sram_we_n_d;
      sram_oe_n_q   <= sram_oe_n_d;
    end
  end

  assign read_data   = read_data_q;
  assign ready       = ready_q;
  assign freeze      = req & ~ready_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;
  assign sram_oe_n   = sram_oe_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Testbench for sram_controller: async SRAM model, word-level reference model
// with per-cycle checking, directed cases and randomized accesses.
// Honours SRAM_READ_CACHE_EN for expected cache-hit behaviour.

module tb_sram_controller;

  localparam int          W    = 3;
  localparam logic [31:0] BASE = 32'd1024;
`ifdef SRAM_READ_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk, rst;
  logic        mem_read, mem_write;
  logic [31:0] address, write_data, read_data;
  logic        ready, freeze;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  // second instance with the minimum wait count
  logic        r2_read;
  logic [31:0] r2_addr, rd2;
  logic        rdy2, frz2;
  logic [17:0] s2_addr;
  logic [15:0] s2_dq_in, unused_s2_dq_out;
  logic        unused_s2_oe, unused_s2_we_n, s2_oe_n;

  int tests = 0;
  int fails = 0;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .freeze(freeze), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(BASE)) u_dut2 (
    .clk(clk), .rst(rst), .mem_read(r2_read), .mem_write(1'b0),
    .address(r2_addr), .write_data(32'h0), .read_data(rd2),
    .ready(rdy2), .freeze(frz2), .sram_addr(s2_addr),
    .sram_dq_out(unused_s2_dq_out), .sram_dq_in(s2_dq_in),
    .sram_dq_oe(unused_s2_oe), .sram_we_n(unused_s2_we_n), .sram_oe_n(s2_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial SRAM contents: halves 2/3 hold 0x1234/0xABCD, others a fixed pattern.
  function automatic logic [15:0] dflt(input logic [17:0] a);
    if (a == 18'd2) return 16'h1234;
    if (a == 18'd3) return 16'hABCD;
    return a[15:0] ^ 16'hC3A5 ^ {a[17:16], 14'h0};
  endfunction

  bit [15:0] sram_mem [0:262143];
  bit        sram_wr  [0:262143];

  function automatic logic [15:0] sram_half(input logic [17:0] a);
    return sram_wr[a] ? sram_mem[a] : dflt(a);
  endfunction

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) begin
      sram_mem[sram_addr] <= sram_dq_out;
      sram_wr[sram_addr]  <= 1'b1;
    end
  end

  assign sram_dq_in = sram_oe_n ? 16'h0 : sram_half(sram_addr);
  assign s2_dq_in   = s2_oe_n ? 16'h0 : dflt(s2_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] off17(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return d[18:2];
  endfunction

  // ---------------- word-level reference model ----------------
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_word(input logic [16:0] off);
    if (ref_mem.exists(int'(off))) return ref_mem[int'(off)];
    return {dflt({off, 1'b1}), dflt({off, 1'b0})};
  endfunction

  bit          busy = 0;
  int          cyc, lat;
  bit          m_wr, m_hit;
  logic [31:0] m_addr, m_data, last_rd, exp_w;
  logic [16:0] m_off;
  bit          c_valid = 0;
  logic [29:0] c_tag;
  logic [31:0] c_data;

  initial begin
    last_rd = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy = 0; c_valid = 0; last_rd = 32'h0;
        check("rst_ready", ready, 0);
        check("rst_read_data", read_data, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_dq_out", sram_dq_out, 0);
        check("rst_dq_oe", sram_dq_oe, 0);
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe_n", sram_oe_n, 1);
      end else begin
        if (!busy && (mem_read || mem_write)) begin
          busy = 1; cyc = 0; m_wr = mem_write; m_addr = address;
          m_data = write_data; m_off = off17(address);
          m_hit = CACHE && !mem_write && c_valid && (c_tag == address[31:2]);
          lat = m_hit ? 1 : 2 * W + 1;
        end
        check("ready", ready, busy && cyc == lat);
        check("freeze", freeze, (mem_read || mem_write) && !(busy && cyc == lat));
        if (busy && !m_hit && cyc >= 1 && cyc <= 2 * W) begin
          check("sram_addr", sram_addr, {m_off, (cyc - 1) >= W});
          if (m_wr) begin
            check("wr_dq_oe", sram_dq_oe, 1);
            check("wr_dq_out", sram_dq_out, ((cyc - 1) >= W) ? m_data[31:16] : m_data[15:0]);
            check("wr_we_n", sram_we_n, ((cyc - 1) % W) == W - 1);
            check("wr_oe_n", sram_oe_n, 1);
          end else begin
            check("rd_dq_oe", sram_dq_oe, 0);
            check("rd_oe_n", sram_oe_n, 0);
            check("rd_we_n", sram_we_n, 1);
          end
        end else begin
          check("idle_we_n", sram_we_n, 1);
          check("idle_oe_n", sram_oe_n, 1);
          check("idle_dq_oe", sram_dq_oe, 0);
        end
        if (busy && cyc == lat) begin
          if (m_wr) begin
            ref_mem[int'(m_off)] = m_data;
            if (c_valid && c_tag == m_addr[31:2]) c_data = m_data;
            check("wr_read_data_hold", read_data, last_rd);
          end else begin
            exp_w = m_hit ? c_data : ref_word(m_off);
            check("read_data", read_data, exp_w);
            last_rd = exp_w;
            c_valid = 1; c_tag = m_addr[31:2]; c_data = exp_w;
          end
          busy = 0;
        end else begin
          check("read_data_hold", read_data, last_rd);
          if (busy) cyc++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output int alat, output logic [31:0] rdat, output int fz);
    mem_read = rd; mem_write = wr; address = a; write_data = d;
    alat = -1; fz = 0; rdat = 32'h0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (freeze) fz++;
      if (ready) begin
        alat = c; rdat = read_data;
        break;
      end
    end
    if (alat < 0) begin
      tests++; fails++;
      $display("FAIL access_timeout: no ready within 64 cycles for address %h", a);
    end
    tick();
    mem_read = 0; mem_write = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          al, fz, kind, k, sel, n, t1, t2;
    logic [31:0] rd, a, d1, d2;
    rst = 0; mem_read = 0; mem_write = 0; address = 0; write_data = 0;
    r2_read = 0; r2_addr = 0;
    repeat (3) tick();
    rst = 1;
    check("ready_after_reset", ready, 0);

    access(0, 1, 32'd1024, 32'hDEADBEEF, al, rd, fz);
    check("wr1024_latency", al, 7);
    check("wr1024_freeze_cycles", fz, 7);
    check("sram_word0", sram_half(18'd0), 32'h0000BEEF);
    check("sram_word1", sram_half(18'd1), 32'h0000DEAD);

    access(1, 0, 32'd1024, 32'h0, al, rd, fz);
    check("rd1024_latency", al, 7);
    check("rd1024_data", rd, 32'hDEADBEEF);
    check("rd1024_freeze_cycles", fz, 7);

    if (CACHE) begin
      access(1, 0, 32'd1024, 32'h0, al, rd, fz);
      check("hit1024_latency", al, 1);
      check("hit1024_data", rd, 32'hDEADBEEF);
      access(0, 1, 32'd1024, 32'h0, al, rd, fz);
      check("wr0_latency", al, 7);
      access(1, 0, 32'd1024, 32'h0, al, rd, fz);
      check("hit_after_wr_latency", al, 1);
      check("hit_after_wr_data", rd, 32'h0);
    end

    access(1, 0, 32'd1028, 32'h0, al, rd, fz);
    check("rd1028_latency", al, 7);
    check("rd1028_data", rd, 32'hABCD1234);

    access(1, 1, 32'd1032, 32'h55AA00FF, al, rd, fz);
    check("both_latency", al, 7);
    check("both_sram_half4", sram_half(18'd4), 32'h000000FF);
    check("both_sram_half5", sram_half(18'd5), 32'h000055AA);
    access(1, 0, 32'd1032, 32'h0, al, rd, fz);
    check("rd1032_data", rd, 32'h55AA00FF);

    // reset in cycle 4 of a write
    mem_write = 1; address = 32'd1036; write_data = 32'h11112222;
    repeat (4) @(posedge clk);
    #1;
    rst = 0;
    #1;
    check("abort_ready", ready, 0);
    check("abort_we_n", sram_we_n, 1);
    check("abort_oe_n", sram_oe_n, 1);
    check("abort_dq_oe", sram_dq_oe, 0);
    check("abort_sram_addr", sram_addr, 0);
    check("abort_dq_out", sram_dq_out, 0);
    check("abort_read_data", read_data, 0);
    check("abort_freeze", freeze, 1);
    mem_write = 0;
    check("abort_half6", sram_half(18'd6), 32'h00002222);
    check("abort_half7", sram_half(18'd7), {16'h0, dflt(18'd7)});
    tick(); tick();
    rst = 1;
    access(1, 0, 32'd1040, 32'h0, al, rd, fz);
    check("post_reset_rd_latency", al, 7);
    check("post_reset_rd_data", rd, {dflt(18'd9), dflt(18'd8)});
    access(0, 1, 32'd1036, 32'h0BADF00D, al, rd, fz);
    access(1, 0, 32'd1036, 32'h0, al, rd, fz);
    check("rewrite1036_data", rd, 32'h0BADF00D);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      k    = $urandom_range(0, 15);
      sel  = $urandom_range(0, 7);
      if (sel == 0)      a = BASE + 32'h0008_0000 + 32'(4 * k);
      else if (sel == 1) a = BASE - 32'(4 * (k + 1));
      else               a = BASE + 32'(4 * k);
      access(kind < 5, kind >= 5, a, $urandom, al, rd, fz);
      repeat ($urandom_range(0, 2)) tick();
    end

    // WAIT_CYCLES=2: two back-to-back reads
    r2_read = 1; r2_addr = 32'd1024; n = 0; t1 = -1; t2 = -1; d1 = 0; d2 = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rdy2) begin
        if (n == 0) begin
          t1 = c; d1 = rd2;
          check("w2_freeze_at_ready", frz2, 0);
        end else begin
          t2 = c; d2 = rd2;
        end
        n++;
      end
      if (n == 2) break;
      tick();
      if (n == 1) r2_addr = 32'd1028;
    end
    r2_read = 0;
    check("w2_first_ready_cycle", t1, 5);
    check("w2_second_ready_cycle", t2, 11);
    check("w2_first_data", d1, {dflt(18'd1), dflt(18'd0)});
    check("w2_second_data", d2, 32'hABCD1234);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
